// File: rtl/party_rsvp_controller_if.sv
// RSVP inputs, status outputs and the decision valid/ack handshake of the party controller.
// master = controller side, slave = environment/consumer side.
interface party_rsvp_controller_if;
    logic       start;
    logic       abort;
    logic       h1;
    logic       h2;
    logic       b1;
    logic       b2;
    logic       decision_ack;
    logic       busy;
    logic [1:0] hiker_cnt;
    logic [1:0] baller_cnt;
    logic       decision_valid;
    logic       p;
    logic       cancel;

    modport master (
        input  start, abort, h1, h2, b1, b2, decision_ack,
        output busy, hiker_cnt, baller_cnt, decision_valid, p, cancel
    );

    modport slave (
        output start, abort, h1, h2, b1, b2, decision_ack,
        input  busy, hiker_cnt, baller_cnt, decision_valid, p, cancel
    );
endinterface

// File: rtl/party_rsvp_controller.sv
// Party RSVP sequencer: collects hiker/baller RSVPs over a window and presents go/cancel.
// Latency: decision visible WINDOW_CYCLES+2 cycles after the Start edge.
// Backpressure: decision held until decision_ack; cooldown then blocks new Starts.
module party_rsvp_controller #(
    parameter int unsigned WINDOW_CYCLES   = 16,
    parameter int unsigned MIN_PER_GROUP   = 1,
    parameter int unsigned COOLDOWN_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    party_rsvp_controller_if.master       bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE,
        S_HOLD,
        S_COOLDOWN
    } state_t;

    localparam logic [7:0] WIN_LAST = 8'(WINDOW_CYCLES - 1);
    localparam logic [7:0] CD_LAST  = 8'(COOLDOWN_CYCLES - 1);
    localparam logic [1:0] MIN_Q    = 2'(MIN_PER_GROUP);

    state_t     state;
    logic [7:0] cnt;
    logic       h1_q, h2_q, b1_q, b2_q;
    logic [1:0] hiker_cnt_q, baller_cnt_q;
    logic       busy_q, valid_q, p_q, cancel_q;

    logic       h1_nx, h2_nx, b1_nx, b2_nx;
    logic [1:0] hiker_nx, baller_nx;
    logic       go;
    logic       abortable;

    always_comb begin
        h1_nx     = h1_q | bus.h1;
        h2_nx     = h2_q | bus.h2;
        b1_nx     = b1_q | bus.b1;
        b2_nx     = b2_q | bus.b2;
        hiker_nx  = {1'b0, h1_nx} + {1'b0, h2_nx};
        baller_nx = {1'b0, b1_nx} + {1'b0, b2_nx};
        go        = (hiker_cnt_q >= MIN_Q) && (baller_cnt_q >= MIN_Q);
        abortable = (state == S_COLLECT) || (state == S_DECIDE) || (state == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= 8'd0;
            h1_q         <= 1'b0;
            h2_q         <= 1'b0;
            b1_q         <= 1'b0;
            b2_q         <= 1'b0;
            hiker_cnt_q  <= 2'd0;
            baller_cnt_q <= 2'd0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            p_q          <= 1'b0;
            cancel_q     <= 1'b0;
        end else if (bus.abort && abortable) begin
            // Abort takes priority over sampling and over a simultaneous ack.
            state        <= S_IDLE;
            h1_q         <= 1'b0;
            h2_q         <= 1'b0;
            b1_q         <= 1'b0;
            b2_q         <= 1'b0;
            hiker_cnt_q  <= 2'd0;
            baller_cnt_q <= 2'd0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            p_q          <= 1'b0;
            cancel_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state        <= S_COLLECT;
                        cnt          <= WIN_LAST;
                        h1_q         <= 1'b0;
                        h2_q         <= 1'b0;
                        b1_q         <= 1'b0;
                        b2_q         <= 1'b0;
                        hiker_cnt_q  <= 2'd0;
                        baller_cnt_q <= 2'd0;
                        busy_q       <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    h1_q         <= h1_nx;
                    h2_q         <= h2_nx;
                    b1_q         <= b1_nx;
                    b2_q         <= b2_nx;
                    hiker_cnt_q  <= hiker_nx;
                    baller_cnt_q <= baller_nx;
                    if (cnt == 8'd0) begin
                        state <= S_DECIDE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_DECIDE: begin
                    valid_q  <= 1'b1;
                    p_q      <= go;
                    cancel_q <= !go;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.decision_ack) begin
                        valid_q  <= 1'b0;
                        p_q      <= 1'b0;
                        cancel_q <= 1'b0;
                        if (COOLDOWN_CYCLES == 0) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= S_COOLDOWN;
                            cnt   <= CD_LAST;
                        end
                    end
                end
                S_COOLDOWN: begin
                    if (cnt == 8'd0) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.hiker_cnt      = hiker_cnt_q;
    assign bus.baller_cnt     = baller_cnt_q;
    assign bus.decision_valid = valid_q;
    assign bus.p              = p_q;
    assign bus.cancel         = cancel_q;

endmodule

// File: tb/tb_party_rsvp_controller.sv
// Directed bench for party_rsvp_controller: default, MIN_PER_GROUP=2 and WINDOW_CYCLES=1 instances.
// Cycle c = interval after edge c-1; inputs driven in cycle c are sampled at edge c.
module tb_party_rsvp_controller;

    logic clk;
    logic rst_n;
    int   nchk;
    int   nerr;
    logic seen_valid;

    party_rsvp_controller_if d0 ();
    party_rsvp_controller_if d2 ();
    party_rsvp_controller_if d1 ();

    party_rsvp_controller dut_def (.clk(clk), .rst_n(rst_n), .bus(d0));
    party_rsvp_controller #(.MIN_PER_GROUP(2)) dut_min2 (.clk(clk), .rst_n(rst_n), .bus(d2));
    party_rsvp_controller #(.WINDOW_CYCLES(1)) dut_w1 (.clk(clk), .rst_n(rst_n), .bus(d1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        rst_n = 1'b0;
        {d0.start, d0.abort, d0.h1, d0.h2, d0.b1, d0.b2, d0.decision_ack} = '0;
        {d2.start, d2.abort, d2.h1, d2.h2, d2.b1, d2.b2, d2.decision_ack} = '0;
        {d1.start, d1.abort, d1.h1, d1.h2, d1.b1, d1.b2, d1.decision_ack} = '0;

        #3;
        chk("rst_busy",  32'(d0.busy), 0);
        chk("rst_valid", 32'(d0.decision_valid), 0);
        chk("rst_p",     32'(d0.p), 0);
        chk("rst_cancel",32'(d0.cancel), 0);
        chk("rst_hcnt",  32'(d0.hiker_cnt), 0);
        chk("rst_bcnt",  32'(d0.baller_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: H2 at cycle 3, B1 at cycle 10; held until ack at 26, cooldown 27..30
        for (int c = 0; c <= 31; c++) begin
            if (c == 4) begin
                chk("t1_hcnt_c4", 32'(d0.hiker_cnt), 1);
                chk("t1_bcnt_c4", 32'(d0.baller_cnt), 0);
            end
            if (c == 11) chk("t1_bcnt_c11", 32'(d0.baller_cnt), 1);
            if (c == 17) chk("t1_valid_c17", 32'(d0.decision_valid), 0);
            if (c == 18) begin
                chk("t1_valid_c18",  32'(d0.decision_valid), 1);
                chk("t1_p_c18",      32'(d0.p), 1);
                chk("t1_cancel_c18", 32'(d0.cancel), 0);
                chk("t1_hcnt_c18",   32'(d0.hiker_cnt), 1);
                chk("t1_bcnt_c18",   32'(d0.baller_cnt), 1);
            end
            if (c == 25) begin
                chk("t1_valid_held", 32'(d0.decision_valid), 1);
                chk("t1_p_held",     32'(d0.p), 1);
            end
            if (c == 27) begin
                chk("t1_valid_c27", 32'(d0.decision_valid), 0);
                chk("t1_p_c27",     32'(d0.p), 0);
                chk("t1_busy_c27",  32'(d0.busy), 1);
            end
            if (c == 30) chk("t1_busy_c30", 32'(d0.busy), 1);
            if (c == 31) begin
                chk("t1_busy_c31", 32'(d0.busy), 0);
                chk("t1_hcnt_idle", 32'(d0.hiker_cnt), 1);
            end
            d0.start        = (c == 0);
            d0.h2           = (c == 3);
            d0.b1           = (c == 10);
            d0.decision_ack = (c == 26);
            @(negedge clk);
        end

        // Test 2: hikers only (H1 twice), ack in first valid cycle, Start during cooldown ignored
        for (int c = 0; c <= 25; c++) begin
            if (c == 18) begin
                chk("t2_hcnt",   32'(d0.hiker_cnt), 2);
                chk("t2_bcnt",   32'(d0.baller_cnt), 0);
                chk("t2_valid",  32'(d0.decision_valid), 1);
                chk("t2_p",      32'(d0.p), 0);
                chk("t2_cancel", 32'(d0.cancel), 1);
            end
            if (c == 19) chk("t2_cancel_clr", 32'(d0.cancel), 0);
            if (c == 22) chk("t2_busy_c22", 32'(d0.busy), 1);
            if (c == 23) chk("t2_busy_c23", 32'(d0.busy), 0);
            if (c == 25) chk("t2_busy_c25", 32'(d0.busy), 0);
            d0.start        = (c == 0) || (c == 20);
            d0.h1           = (c == 2) || (c == 7);
            d0.h2           = (c == 5);
            d0.decision_ack = (c == 18);
            @(negedge clk);
        end

        // Test 5a: abort mid-COLLECT
        seen_valid = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            if (d0.decision_valid) seen_valid = 1'b1;
            if (c == 6) begin
                chk("t5a_busy", 32'(d0.busy), 0);
                chk("t5a_hcnt", 32'(d0.hiker_cnt), 0);
                chk("t5a_bcnt", 32'(d0.baller_cnt), 0);
            end
            d0.start = (c == 0);
            d0.h1    = (c == 2);
            d0.b1    = (c == 3);
            d0.abort = (c == 5);
            @(negedge clk);
        end
        chk("t5a_no_valid", 32'(seen_valid), 0);

        // Test 5b: abort together with ack in HOLD, then Start+Abort in IDLE
        for (int c = 0; c <= 22; c++) begin
            if (c == 18) chk("t5b_valid_c18", 32'(d0.decision_valid), 1);
            if (c == 19) begin
                chk("t5b_busy",  32'(d0.busy), 0);
                chk("t5b_valid", 32'(d0.decision_valid), 0);
                chk("t5b_p",     32'(d0.p), 0);
                chk("t5b_hcnt",  32'(d0.hiker_cnt), 0);
                chk("t5b_bcnt",  32'(d0.baller_cnt), 0);
            end
            if (c == 21) chk("t5b_start_abort_idle", 32'(d0.busy), 0);
            d0.start        = (c == 0) || (c == 20);
            d0.h1           = (c == 1);
            d0.b1           = (c == 2);
            d0.decision_ack = (c == 18);
            d0.abort        = (c == 18) || (c == 20);
            @(negedge clk);
        end

        // Test 3: MIN_PER_GROUP=2, B2 pulsed three times, then again with B1
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c <= 24; c++) begin
                if (c == 18) begin
                    chk("t3_hcnt",   32'(d2.hiker_cnt), 2);
                    chk("t3_bcnt",   32'(d2.baller_cnt), (r == 0) ? 1 : 2);
                    chk("t3_p",      32'(d2.p), (r == 0) ? 0 : 1);
                    chk("t3_cancel", 32'(d2.cancel), (r == 0) ? 1 : 0);
                end
                d2.start        = (c == 0);
                d2.h1           = (c == 1);
                d2.h2           = (c == 2);
                d2.b2           = (c >= 3) && (c <= 5);
                d2.b1           = (r == 1) && (c == 6);
                d2.decision_ack = (c == 18);
                @(negedge clk);
            end
        end

        // Test 4: WINDOW_CYCLES=1, single sample at edge 1, ack in cycle 3
        for (int c = 0; c <= 5; c++) begin
            if (c == 2) begin
                chk("t4_valid_c2", 32'(d1.decision_valid), 0);
                chk("t4_hcnt_c2",  32'(d1.hiker_cnt), 1);
                chk("t4_bcnt_c2",  32'(d1.baller_cnt), 1);
            end
            if (c == 3) begin
                chk("t4_valid_c3", 32'(d1.decision_valid), 1);
                chk("t4_p_c3",     32'(d1.p), 1);
            end
            if (c == 4) begin
                chk("t4_valid_c4", 32'(d1.decision_valid), 0);
                chk("t4_busy_c4",  32'(d1.busy), 1);
            end
            d1.start        = (c == 0);
            d1.h1           = (c == 1);
            d1.b1           = (c == 1);
            d1.decision_ack = (c == 3);
            @(negedge clk);
        end

        // Test 6: async reset between edges in HOLD, then a clean round
        for (int c = 0; c <= 20; c++) begin
            if (c == 20) begin
                chk("t6_valid_pre", 32'(d0.decision_valid), 1);
                #2;
                rst_n = 1'b0;
                #1;
                chk("t6_valid", 32'(d0.decision_valid), 0);
                chk("t6_p",     32'(d0.p), 0);
                chk("t6_busy",  32'(d0.busy), 0);
                chk("t6_hcnt",  32'(d0.hiker_cnt), 0);
                chk("t6_bcnt",  32'(d0.baller_cnt), 0);
            end
            d0.start = (c == 0);
            d0.h1    = (c == 1);
            d0.b2    = (c == 1);
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int c = 0; c <= 19; c++) begin
            if (c == 18) begin
                chk("t6_round_valid", 32'(d0.decision_valid), 1);
                chk("t6_round_p",     32'(d0.p), 1);
                chk("t6_round_hcnt",  32'(d0.hiker_cnt), 1);
            end
            d0.start        = (c == 0);
            d0.b1           = (c == 4);
            d0.h2           = (c == 4);
            d0.decision_ack = (c == 18);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
